// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite responder exposing REG_N byte-strobed RW registers; one outstanding write and read.
// Optional macro AXI4_LITE_SLV_RO_EN maps RO_N read-only status words (ro_in) after the RW bank.
module axi4_lite_reg_slave #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REG_N = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int RO_N = 4
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [ADDR_W-1:0]       AWADDR,
  input  logic [2:0]              AWPROT,
  input  logic                    WVALID,
  output logic                    WREADY,
  input  logic [DATA_W-1:0]       WDATA,
  input  logic [DATA_W/8-1:0]     WSTRB,
  output logic                    BVALID,
  input  logic                    BREADY,
  output logic                    BRESP,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  input  logic [ADDR_W-1:0]       ARADDR,
  input  logic [2:0]              ARPROT,
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic [DATA_W-1:0]       RDATA,
  output logic                    RRESP,
`ifdef AXI4_LITE_SLV_RO_EN
  input  logic [RO_N*DATA_W-1:0]  ro_in,
`endif
  output logic [REG_N*DATA_W-1:0] regs_out,
  output logic [REG_N-1:0]        wr_stb
);
  localparam int BL = $clog2(DATA_W/8);
  localparam int IDX_W = ADDR_W - BL;
  localparam int NB = DATA_W/8;
`ifdef AXI4_LITE_SLV_RO_EN
  localparam int RD_END = REG_N + RO_N;
`else
  // no status words are mapped, so the readable range stops at the RW bank
  localparam int RD_END = REG_N + 0*RO_N;
`endif

  typedef enum logic [1:0] {W_IDLE, W_WAIT_W, W_WAIT_AW, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t wstate, wnext;
  rstate_t rstate, rnext;

  logic [DATA_W-1:0] regs [REG_N];
  logic [IDX_W-1:0]  aw_idx_p0, wr_idx, rd_idx;
  logic [DATA_W-1:0] wdata_p0, wr_data, rd_word;
  logic [NB-1:0]     wstrb_p0, wr_strb;
  logic              commit, wr_hit, rd_acc, rd_hit;
  logic              unused_ok;

  assign unused_ok = ^{AWPROT, ARPROT, AWADDR[BL-1:0], ARADDR[BL-1:0]};

  always_comb begin
    wnext   = wstate;
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    commit  = 1'b0;
    case (wstate)
      W_IDLE: begin
        AWREADY = 1'b1;
        WREADY  = 1'b1;
        if (AWVALID && WVALID) begin
          commit = 1'b1;
          wnext  = W_RESP;
        end else if (AWVALID) begin
          wnext = W_WAIT_W;
        end else if (WVALID) begin
          wnext = W_WAIT_AW;
        end
      end
      W_WAIT_W: begin
        WREADY = 1'b1;
        if (WVALID) begin
          commit = 1'b1;
          wnext  = W_RESP;
        end
      end
      W_WAIT_AW: begin
        AWREADY = 1'b1;
        if (AWVALID) begin
          commit = 1'b1;
          wnext  = W_RESP;
        end
      end
      W_RESP: if (BREADY) wnext = W_IDLE;
      default: wnext = W_IDLE;
    endcase
    if (ARESET) begin
      AWREADY = 1'b0;
      WREADY  = 1'b0;
      commit  = 1'b0;
    end
  end

  always_comb begin
    rnext   = rstate;
    ARREADY = 1'b0;
    rd_acc  = 1'b0;
    case (rstate)
      R_IDLE: begin
        ARREADY = 1'b1;
        if (ARVALID) begin
          rd_acc = 1'b1;
          rnext  = R_DATA;
        end
      end
      R_DATA: if (RREADY) rnext = R_IDLE;
      default: rnext = R_IDLE;
    endcase
    if (ARESET) begin
      ARREADY = 1'b0;
      rd_acc  = 1'b0;
    end
  end

  assign BVALID = (wstate == W_RESP);
  assign RVALID = (rstate == R_DATA);

  // whichever half arrived first was parked in the _p0 holding registers
  assign wr_idx  = (wstate == W_WAIT_W)  ? aw_idx_p0 : AWADDR[ADDR_W-1:BL];
  assign wr_data = (wstate == W_WAIT_AW) ? wdata_p0  : WDATA;
  assign wr_strb = (wstate == W_WAIT_AW) ? wstrb_p0  : WSTRB;
  assign wr_hit  = wr_idx < IDX_W'(REG_N);
  assign rd_idx  = ARADDR[ADDR_W-1:BL];
  assign rd_hit  = rd_idx < IDX_W'(RD_END);

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < REG_N; k++)
      if (rd_idx == IDX_W'(k)) rd_word = regs[k];
`ifdef AXI4_LITE_SLV_RO_EN
    for (int k = 0; k < RO_N; k++)
      if (rd_idx == IDX_W'(REG_N + k)) rd_word = ro_in[k*DATA_W +: DATA_W];
`endif
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wstate <= W_IDLE;
      rstate <= R_IDLE;
    end else begin
      wstate <= wnext;
      rstate <= rnext;
    end
  end

  always_ff @(posedge ACLK) begin
    if (wstate == W_IDLE && AWVALID && !WVALID) aw_idx_p0 <= AWADDR[ADDR_W-1:BL];
    if (wstate == W_IDLE && WVALID && !AWVALID) begin
      wdata_p0 <= WDATA;
      wstrb_p0 <= WSTRB;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int k = 0; k < REG_N; k++) regs[k] <= RESET_VAL;
      wr_stb <= '0;
      BRESP  <= 1'b0;
      RRESP  <= 1'b0;
      RDATA  <= '0;
    end else begin
      wr_stb <= '0;
      if (commit) begin
        BRESP <= !wr_hit;
        for (int k = 0; k < REG_N; k++)
          if (wr_hit && wr_idx == IDX_W'(k)) begin
            wr_stb[k] <= 1'b1;
            for (int i = 0; i < NB; i++)
              if (wr_strb[i]) regs[k][i*8 +: 8] <= wr_data[i*8 +: 8];
          end
      end
      if (rd_acc) begin
        RDATA <= rd_word;
        RRESP <= !rd_hit;
      end
    end
  end

  for (genvar k = 0; k < REG_N; k++) begin : g_out
    assign regs_out[k*DATA_W +: DATA_W] = regs[k];
  end

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Bench for axi4_lite_reg_slave: transaction-level register model plus directed vectors.
`timescale 1ns/1ps
module tb_axi4_lite_reg_slave;
  localparam int REG_N = 8;
`ifdef AXI4_LITE_SLV_RO_EN
  localparam int RO_N = 4;
  logic [RO_N*32-1:0] ro_in;
`endif

  logic ACLK = 1'b0;
  logic ARESET, AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY, BRESP;
  logic ARVALID, ARREADY, RVALID, RREADY, RRESP;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [2:0]  AWPROT, ARPROT;
  logic [3:0]  WSTRB;
  logic [REG_N*32-1:0] regs_out;
  logic [REG_N-1:0]    wr_stb;

  int n_cmp = 0;
  int n_bad = 0;

  axi4_lite_reg_slave dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
`ifdef AXI4_LITE_SLV_RO_EN
    .ro_in(ro_in),
`endif
    .regs_out(regs_out), .wr_stb(wr_stb)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: AW and W halves are queued separately and paired in arrival order.
  logic [31:0] m_regs [REG_N];
  logic [REG_N-1:0] m_stb;
  logic m_bv, m_bresp, m_rv, m_rresp, m_on = 1'b0;
  logic [31:0] m_rdata;
  logic [31:0] aw_q [$];
  logic [31:0] wd_q [$];
  logic [3:0]  ws_q [$];
  logic [31:0] c_a, c_d;
  logic [3:0]  c_s;
  int unsigned c_idx;

  function automatic void model_read(input logic [31:0] addr, output logic [31:0] d,
                                     output logic e);
    int unsigned idx = int'(addr[31:2]);
    d = 32'h0;
    e = 1'b1;
    if (idx < REG_N) begin
      d = m_regs[idx];
      e = 1'b0;
    end
`ifdef AXI4_LITE_SLV_RO_EN
    else if (idx < REG_N + RO_N) begin
      d = ro_in[(idx-REG_N)*32 +: 32];
      e = 1'b0;
    end
`endif
  endfunction

  always @(negedge ACLK) begin
    if (m_on) begin
      for (int k = 0; k < REG_N; k++)
        chk($sformatf("model_reg%0d", k), regs_out[k*32 +: 32], m_regs[k]);
      chk("model_wr_stb", 32'(wr_stb), 32'(m_stb));
      chk("model_bvalid", 32'(BVALID), 32'(m_bv));
      if (m_bv) chk("model_bresp", 32'(BRESP), 32'(m_bresp));
      chk("model_rvalid", 32'(RVALID), 32'(m_rv));
      if (m_rv) begin
        chk("model_rdata", RDATA, m_rdata);
        chk("model_rresp", 32'(RRESP), 32'(m_rresp));
      end
    end
    // advance the model by what the coming rising edge will sample
    if (ARESET) begin
      for (int k = 0; k < REG_N; k++) m_regs[k] = 32'h0;
      m_stb = '0; m_bv = 1'b0; m_bresp = 1'b0;
      m_rv = 1'b0; m_rresp = 1'b0; m_rdata = 32'h0;
      aw_q.delete(); wd_q.delete(); ws_q.delete();
      m_on = 1'b1;
    end else if (m_on) begin
      m_stb = '0;
      if (m_rv && RREADY) m_rv = 1'b0;
      if (ARVALID && ARREADY) begin
        model_read(ARADDR, m_rdata, m_rresp);
        m_rv = 1'b1;
      end
      if (m_bv && BREADY) m_bv = 1'b0;
      if (AWVALID && AWREADY) aw_q.push_back(AWADDR);
      if (WVALID && WREADY) begin
        wd_q.push_back(WDATA);
        ws_q.push_back(WSTRB);
      end
      if (aw_q.size() > 0 && wd_q.size() > 0) begin
        c_a = aw_q.pop_front();
        c_d = wd_q.pop_front();
        c_s = ws_q.pop_front();
        c_idx = int'(c_a[31:2]);
        if (c_idx < REG_N) begin
          for (int i = 0; i < 4; i++)
            if (c_s[i]) m_regs[c_idx][i*8 +: 8] = c_d[i*8 +: 8];
          m_stb[c_idx] = 1'b1;
          m_bresp = 1'b0;
        end else begin
          m_bresp = 1'b1;
        end
        m_bv = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic mid();
    @(negedge ACLK);
  endtask

  task automatic wr_both(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    AWVALID = 1'b1; AWADDR = a;
    WVALID  = 1'b1; WDATA  = d; WSTRB = s;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESET = 1'b1;
    AWVALID = 1'b0; AWADDR = '0; AWPROT = '0;
    WVALID = 1'b0; WDATA = '0; WSTRB = '0;
    ARVALID = 1'b0; ARADDR = '0; ARPROT = '0;
    BREADY = 1'b1; RREADY = 1'b1;
`ifdef AXI4_LITE_SLV_RO_EN
    ro_in = {32'h0000_0004, 32'h0000_0003, 32'h0000_0002, 32'hCAFE_0001};
`endif

    // reset then idle
    tick(); tick(); mid();
    chk("awready_in_reset", 32'(AWREADY), 32'd0);
    chk("arready_in_reset", 32'(ARREADY), 32'd0);
    tick(); ARESET = 1'b0;
    mid();
    chk("awready_idle", 32'(AWREADY), 32'd1);
    chk("wready_idle", 32'(WREADY), 32'd1);
    chk("arready_idle", 32'(ARREADY), 32'd1);
    chk("bvalid_idle", 32'(BVALID), 32'd0);
    chk("rvalid_idle", 32'(RVALID), 32'd0);
    chk("regs_zero", 32'(regs_out != '0), 32'd0);

    // AW and W together, then read back
    tick();
    wr_both(32'h04, 32'hDEADBEEF, 4'hF);
    mid();
    chk("reg1_write", regs_out[63:32], 32'hDEADBEEF);
    chk("wr_stb_reg1", 32'(wr_stb), 32'h02);
    chk("bvalid_after_write", 32'(BVALID), 32'd1);
    chk("bresp_ok", 32'(BRESP), 32'd0);
    ARVALID = 1'b1; ARADDR = 32'h04;
    tick(); ARVALID = 1'b0;
    mid();
    chk("rvalid_read1", 32'(RVALID), 32'd1);
    chk("rdata_read1", RDATA, 32'hDEADBEEF);
    chk("rresp_read1", 32'(RRESP), 32'd0);

    // W three cycles ahead of AW, single byte strobe
    tick();
    wr_both(32'h08, 32'h11223344, 4'hF);
    mid();
    chk("reg2_init", regs_out[95:64], 32'h11223344);
    tick();
    WVALID = 1'b1; WDATA = 32'h000000AA; WSTRB = 4'h1;
    tick(); WVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("awready_wait_aw", 32'(AWREADY), 32'd1);
      chk("wready_wait_aw", 32'(WREADY), 32'd0);
      tick();
    end
    AWVALID = 1'b1; AWADDR = 32'h08;
    tick(); AWVALID = 1'b0;
    mid();
    chk("reg2_byte0", regs_out[95:64], 32'h112233AA);
    chk("wr_stb_reg2", 32'(wr_stb), 32'h04);

    // BREADY low for 5 cycles with the next write already waiting
    tick();
    BREADY = 1'b0;
    wr_both(32'h0C, 32'hFFFF5555, 4'h3);
    AWVALID = 1'b1; AWADDR = 32'h10; WVALID = 1'b1; WDATA = 32'h00000077; WSTRB = 4'hF;
    for (int i = 0; i < 5; i++) begin
      mid();
      chk("bvalid_held", 32'(BVALID), 32'd1);
      chk("bresp_held", 32'(BRESP), 32'd0);
      chk("awready_held", 32'(AWREADY), 32'd0);
      chk("wready_held", 32'(WREADY), 32'd0);
      tick();
    end
    chk("reg3_half", regs_out[127:96], 32'h00005555);
    BREADY = 1'b1;
    tick();
    mid();
    chk("bvalid_released", 32'(BVALID), 32'd0);
    chk("awready_after_b", 32'(AWREADY), 32'd1);
    chk("reg4_not_yet", regs_out[159:128], 32'h0);
    tick(); AWVALID = 1'b0; WVALID = 1'b0;
    mid();
    chk("reg4_write", regs_out[159:128], 32'h00000077);
    chk("wr_stb_reg4", 32'(wr_stb), 32'h10);

    // out of range write and read together
    tick();
    AWVALID = 1'b1; AWADDR = 32'h40; WVALID = 1'b1; WDATA = 32'h12345678; WSTRB = 4'hF;
    ARVALID = 1'b1; ARADDR = 32'h40;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    mid();
    chk("bresp_oor", 32'(BRESP), 32'd1);
    chk("wr_stb_oor", 32'(wr_stb), 32'h0);
    chk("rdata_oor", RDATA, 32'h0);
    chk("rresp_oor", 32'(RRESP), 32'd1);

    // last register, zero strobe, ignored low address bits
    tick();
    wr_both(32'h1F, 32'hA5A5A5A5, 4'h0);
    mid();
    chk("wr_stb_zero_strb", 32'(wr_stb), 32'h80);
    chk("reg7_unchanged", regs_out[255:224], 32'h0);
    chk("bresp_zero_strb", 32'(BRESP), 32'd0);

    // read and write of the same register on one edge returns the old value
    tick();
    ARVALID = 1'b1; ARADDR = 32'h04;
    wr_both(32'h04, 32'h01020304, 4'hF);
    ARVALID = 1'b0;
    mid();
    chk("rdata_old_value", RDATA, 32'hDEADBEEF);
    chk("reg1_new_value", regs_out[63:32], 32'h01020304);

    // first index past the RW bank
    tick();
    wr_both(32'h20, 32'h55AA55AA, 4'hF);
    mid();
    chk("bresp_idx8", 32'(BRESP), 32'd1);
    ARVALID = 1'b1; ARADDR = 32'h20;
    tick(); ARVALID = 1'b0;
    mid();
`ifdef AXI4_LITE_SLV_RO_EN
    chk("rdata_ro0", RDATA, 32'hCAFE0001);
    chk("rresp_ro0", 32'(RRESP), 32'd0);
`else
    chk("rdata_idx8", RDATA, 32'h0);
    chk("rresp_idx8", 32'(RRESP), 32'd1);
`endif

    // reset while a write waits for W and a read response is held
    tick();
    RREADY = 1'b0;
    AWVALID = 1'b1; AWADDR = 32'h0C;
    ARVALID = 1'b1; ARADDR = 32'h08;
    tick(); AWVALID = 1'b0; ARVALID = 1'b0;
    mid();
    chk("awready_wait_w", 32'(AWREADY), 32'd0);
    chk("wready_wait_w", 32'(WREADY), 32'd1);
    chk("rvalid_held", 32'(RVALID), 32'd1);
    tick(); ARESET = 1'b1;
    mid();
    chk("wready_forced_low", 32'(WREADY), 32'd0);
    tick(); ARESET = 1'b0; RREADY = 1'b1;
    mid();
    chk("bvalid_after_rst", 32'(BVALID), 32'd0);
    chk("rvalid_after_rst", 32'(RVALID), 32'd0);
    chk("regs_after_rst", 32'(regs_out != '0), 32'd0);
    chk("awready_after_rst", 32'(AWREADY), 32'd1);
    chk("wready_after_rst", 32'(WREADY), 32'd1);
    chk("arready_after_rst", 32'(ARREADY), 32'd1);

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
